alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/alu_base_ops.sv | 37 +++
 rtl/alu_muldiv.sv | 211 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/multiply-divide unit: default width,
// op-code constants for alu_ctrl, FSM state encoding and operand-sign helpers.
package alu_pkg;

    localparam int ALU_DATA_WIDTH = 32;

    // Base op codes: {func3, func7[5]}
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_OR   = 4'b1100;
    localparam logic [3:0] OP_AND  = 4'b1110;

    // M-extension func3 codes
    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } alu_state_e;

    // Operand A is treated as signed for these M ops
    function automatic logic a_is_signed(input logic [2:0] f3);
        logic r;
        case (f3)
            M_MULH, M_MULHSU, M_DIV, M_REM: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    // Operand B is treated as signed for these M ops
    function automatic logic b_is_signed(input logic [2:0] f3);
        logic r;
        case (f3)
            M_MULH, M_DIV, M_REM: r = 1'b1;
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_base_ops.sv
// Single-cycle base integer operations. Shifts move B by A[SHAMT_W-1:0];
// unlisted codes produce zero.
module alu_base_ops
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);

    logic [SHAMT_W-1:0] shamt_s;

    assign shamt_s = a[SHAMT_W-1:0];

    // Decode the base op code into a result
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = b - a;
            OP_SLL:  result = b << shamt_s;
            OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = b >> shamt_s;
            OP_SRA:  result = $unsigned($signed(b) >>> shamt_s);
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_muldiv.sv
// ALU with iterative multiply (shift-add) and divide (restoring), one bit per
// cycle over DATA_WIDTH cycles on operand magnitudes, signs fixed on the final
// step. Valid/ready handshake on both sides; result held in DONE until taken.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] bus_A,
    input  logic [DATA_WIDTH-1:0] bus_B,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  busy
);

    localparam int W = DATA_WIDTH;

    alu_state_e         state_r;
    logic [W-1:0]       hi_r;        // partial product high / partial remainder
    logic [W-1:0]       lo_r;        // multiplier bits / dividend-quotient bits
    logic [W-1:0]       opb_r;       // multiplicand / divisor magnitude
    logic [W-1:0]       a_raw_r;     // original A, returned for REM by zero
    logic [2:0]         func3_r;
    logic               neg_q_r;     // negate product / quotient at the end
    logic               neg_r_r;     // negate remainder at the end
    logic               dz_r;        // divisor was zero
    logic [SHAMT_W-1:0] cnt_r;

    logic               accept_s;
    logic [2:0]         func3_in_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [W-1:0]       a_mag_s;
    logic [W-1:0]       b_mag_s;
    logic [W-1:0]       base_res_s;
    logic [W:0]         mul_sum_s;
    logic [W-1:0]       mul_hi_nxt_s;
    logic [W-1:0]       mul_lo_nxt_s;
    logic [W:0]         div_shift_s;
    logic [W:0]         div_diff_s;
    logic [W-1:0]       rem_nxt_s;
    logic [W-1:0]       quo_nxt_s;
    logic [2*W-1:0]     prod_s;
    logic [2*W-1:0]     prod_fix_s;
    logic [W-1:0]       quo_fix_s;
    logic [W-1:0]       rem_fix_s;
    logic [W-1:0]       final_s;
    logic               last_iter_s;

    assign in_ready    = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    assign accept_s    = in_valid && in_ready && !flush;
    assign busy        = (state_r == ST_MUL) || (state_r == ST_DIV);
    assign func3_in_s  = alu_ctrl[3:1];
    assign last_iter_s = (cnt_r == SHAMT_W'(W - 1));

    alu_base_ops #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHAMT_W    (SHAMT_W)
    ) u_base (
        .op     (alu_ctrl[3:0]),
        .a      (bus_A),
        .b      (bus_B),
        .result (base_res_s)
    );

    // Operand signs and magnitudes for an M op being accepted
    always_comb begin
        a_neg_s = a_is_signed(func3_in_s) & bus_A[W-1];
        b_neg_s = b_is_signed(func3_in_s) & bus_B[W-1];
        if (a_neg_s) begin
            a_mag_s = -bus_A;
        end else begin
            a_mag_s = bus_A;
        end
        if (b_neg_s) begin
            b_mag_s = -bus_B;
        end else begin
            b_mag_s = bus_B;
        end
    end

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        if (lo_r[0]) begin
            mul_sum_s = {1'b0, hi_r} + {1'b0, opb_r};
        end else begin
            mul_sum_s = {1'b0, hi_r};
        end
        mul_hi_nxt_s = mul_sum_s[W:1];
        mul_lo_nxt_s = {mul_sum_s[0], lo_r[W-1:1]};

        div_shift_s = {hi_r, lo_r[W-1]};
        div_diff_s  = div_shift_s - {1'b0, opb_r};
        if (!div_diff_s[W]) begin
            rem_nxt_s = div_diff_s[W-1:0];
            quo_nxt_s = {lo_r[W-2:0], 1'b1};
        end else begin
            rem_nxt_s = div_shift_s[W-1:0];
            quo_nxt_s = {lo_r[W-2:0], 1'b0};
        end
    end

    // Sign correction and selection of the result written on the last step
    always_comb begin
        prod_s = {mul_hi_nxt_s, mul_lo_nxt_s};
        if (neg_q_r) begin
            prod_fix_s = -prod_s;
            quo_fix_s  = -quo_nxt_s;
        end else begin
            prod_fix_s = prod_s;
            quo_fix_s  = quo_nxt_s;
        end
        if (neg_r_r) begin
            rem_fix_s = -rem_nxt_s;
        end else begin
            rem_fix_s = rem_nxt_s;
        end
        final_s = '0;
        case (func3_r)
            M_MUL:                     final_s = prod_fix_s[W-1:0];
            M_MULH, M_MULHSU, M_MULHU: final_s = prod_fix_s[2*W-1:W];
            M_DIV, M_DIVU:             final_s = dz_r ? {W{1'b1}} : quo_fix_s;
            M_REM, M_REMU:             final_s = dz_r ? a_raw_r : rem_fix_s;
            default:                   final_s = '0;
        endcase
    end

    // Control FSM, iteration datapath and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
            bus_out   <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            opb_r     <= '0;
            a_raw_r   <= '0;
            func3_r   <= 3'b000;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            dz_r      <= 1'b0;
            cnt_r     <= '0;
        end else if (flush) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
            bus_out   <= '0;
            cnt_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s && !alu_ctrl[4]) begin
                        state_r   <= ST_DONE;
                        out_valid <= 1'b1;
                        bus_out   <= base_res_s;
                    end else if (accept_s) begin
                        state_r   <= func3_in_s[2] ? ST_DIV : ST_MUL;
                        out_valid <= 1'b0;
                        bus_out   <= '0;
                        hi_r      <= '0;
                        lo_r      <= a_mag_s;
                        opb_r     <= b_mag_s;
                        a_raw_r   <= bus_A;
                        func3_r   <= func3_in_s;
                        neg_q_r   <= a_neg_s ^ b_neg_s;
                        neg_r_r   <= a_neg_s;
                        dz_r      <= (bus_B == '0);
                        cnt_r     <= '0;
                    end else if ((state_r == ST_DONE) && out_ready) begin
                        state_r   <= ST_IDLE;
                        out_valid <= 1'b0;
                        bus_out   <= '0;
                    end else begin
                        state_r   <= state_r;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (state_r == ST_MUL) begin
                        hi_r <= mul_hi_nxt_s;
                        lo_r <= mul_lo_nxt_s;
                    end else begin
                        hi_r <= rem_nxt_s;
                        lo_r <= quo_nxt_s;
                    end
                    if (last_iter_s) begin
                        state_r   <= ST_DONE;
                        out_valid <= 1'b1;
                        bus_out   <= final_s;
                        cnt_r     <= '0;
                    end else begin
                        cnt_r     <= cnt_r + SHAMT_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                    bus_out   <= '0;
                    cnt_r     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized and directed bench for alu_muldiv (DATA_WIDTH = 32) against a
// plain-arithmetic reference model.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   alu_ctrl = 5'd0;
    logic [W-1:0] bus_A = '0;
    logic [W-1:0] bus_B = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] bus_out;
    logic         busy;

    int checks = 0;
    int errors = 0;

    alu_muldiv #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .bus_A     (bus_A),
        .bus_B     (bus_B),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bus_out   (bus_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model from the arithmetic definitions of each operation
    function automatic logic [31:0] ref_model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int          si_a, si_b;
        int unsigned sh;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        sh = a % 32;
        si_a = a;
        si_b = b;
        if (!c[4]) begin
            case (c[3:0])
                4'b0000: return a + b;
                4'b0001: return b - a;
                4'b0010: return b << sh;
                4'b0100: return (si_a < si_b) ? 32'd1 : 32'd0;
                4'b0110: return (a < b) ? 32'd1 : 32'd0;
                4'b1000: return a ^ b;
                4'b1010: return b >> sh;
                4'b1011: begin p = sb >> sh; return p[31:0]; end
                4'b1100: return a | b;
                4'b1110: return a & b;
                default: return 32'd0;
            endcase
        end
        case (c[3:1])
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(si_a / si_b);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(si_a % si_b);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op, measure latency, check result, hold it, then drain it
    task automatic run_op(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int hold, input string tag);
        int           exp_lat, lat;
        logic         bad_busy, bad_zero, bad_hold;
        logic [31:0]  held;
        exp_lat = ctrl[4] ? W + 1 : 1;
        @(negedge clk);
        alu_ctrl = ctrl; bus_A = a; bus_B = b; in_valid = 1'b1; out_ready = 1'b0;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        lat = 0; bad_busy = 1'b0; bad_zero = 1'b0;
        for (int n = 1; n <= W + 8 && lat == 0; n++) begin
            @(negedge clk);
            in_valid = 1'b0; alu_ctrl = 5'($urandom); bus_A = $urandom; bus_B = $urandom;
            if (out_valid) begin
                lat = n;
            end else begin
                if (bus_out != 32'd0) bad_zero = 1'b1;
                if (ctrl[4] && (in_ready || !busy)) bad_busy = 1'b1;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, bus_out, exp);
        check({tag, "_out_zero_while_invalid"}, 32'(bad_zero), 32'd0);
        if (ctrl[4]) check({tag, "_busy_not_ready"}, 32'(bad_busy), 32'd0);
        held = bus_out; bad_hold = 1'b0;
        for (int n = 0; n < hold; n++) begin
            @(negedge clk);
            if (!out_valid || bus_out != held || in_ready || busy) bad_hold = 1'b1;
        end
        if (hold > 0) check({tag, "_hold_stable"}, 32'(bad_hold), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_single_transfer"}, 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic        bad;
        logic [4:0]  c;
        logic [31:0] a, b;

        // reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bus_out", bus_out, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // back-to-back base ops
        out_ready = 1'b1;
        alu_ctrl = 5'b0_000_0; bus_A = 32'd5; bus_B = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        check("b2b_add_valid", 32'(out_valid), 32'd1);
        check("b2b_add", bus_out, 32'd12);
        check("b2b_ready", 32'(in_ready), 32'd1);
        alu_ctrl = 5'b0_000_1; bus_A = 32'd3; bus_B = 32'd10;
        @(negedge clk);
        check("b2b_sub_valid", 32'(out_valid), 32'd1);
        check("b2b_sub", bus_out, 32'd7);
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_idle_valid", 32'(out_valid), 32'd0);
        check("b2b_idle_bus", bus_out, 32'd0);
        out_ready = 1'b0;

        // directed corner cases
        run_op(5'b1_001_0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh");
        run_op(5'b1_011_0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu");
        run_op(5'b1_100_0, 32'd7, 32'd0, 32'hFFFF_FFFF, 0, "div_by0");
        run_op(5'b1_110_0, 32'd7, 32'd0, 32'd7, 0, "rem_by0");
        run_op(5'b1_100_0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf");
        run_op(5'b1_110_0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "rem_ovf");
        run_op(5'b1_100_0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "div_neg");
        run_op(5'b1_110_0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "rem_neg");
        run_op(5'b0_101_1, 32'h24, 32'h8000_0000, 32'hF800_0000, 5, "sra_hold");

        // randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            c = 5'($urandom);
            a = pick_operand();
            b = pick_operand();
            run_op(c, a, b, ref_model(c, a, b), int'($urandom_range(0, 3)), "rnd");
        end

        // reset in the middle of a divide
        @(negedge clk);
        alu_ctrl = 5'b1_101_0; bus_A = 32'd100; bus_B = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("mid_div_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_div_rst_busy", 32'(busy), 32'd0);
        check("mid_div_rst_valid", 32'(out_valid), 32'd0);
        check("mid_div_rst_bus", bus_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (W + 8) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        check("mid_div_no_stale", 32'(bad), 32'd0);
        check("mid_div_in_ready", 32'(in_ready), 32'd1);

        // flush in the middle of a multiply
        alu_ctrl = 5'b1_000_0; bus_A = 32'd1234; bus_B = 32'd5678; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        bad = 1'b0;
        repeat (W + 8) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        check("flush_no_result", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
